// File: rtl/addsub_pkg.sv
// Shared types and widths for the add/sub result accumulator.
package addsub_pkg;

    localparam int OPND_W = 6;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_accum_sat_add.sv
// Combinational saturating adder: signed accumulator plus a sign-extended
// 6-bit operand, clamped to the accumulator range.
module sat_add
    import addsub_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic        [OPND_W-1:0] opnd_i,
    output logic signed [ACC_W-1:0]  sum_o,
    output logic                     clamp_o
);

    logic [ACC_W:0] wide;

    // One guard bit is enough: |operand| never exceeds half the accumulator range.
    always_comb begin
        wide    = {acc_i[ACC_W-1], acc_i}
                + {{(ACC_W + 1 - OPND_W){opnd_i[OPND_W-1]}}, opnd_i};
        clamp_o = wide[ACC_W] ^ wide[ACC_W-1];
        sum_o   = wide[ACC_W-1:0];
        if (clamp_o) begin
            sum_o = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/addsub_accum.sv
// Accumulates NUM_TERMS signed add/sub results with saturation and hands the
// total downstream through a valid/ready handshake.
//
// state    | meaning
// ST_IDLE  | waiting for start; last result and flag held on the outputs
// ST_ACCUM | in_ready high, one term summed per in_valid cycle
// ST_DONE  | out_valid high, result frozen until out_ready
module addsub_accum
    import addsub_pkg::*;
#(
    parameter int NUM_TERMS = 4,
    parameter int ACC_W     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [OPND_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_acc,
    output logic                    out_ovf,
    output logic                    busy,
    output logic [CNT_W-1:0]        term_cnt
);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;

    logic signed [ACC_W-1:0] sat_sum;
    logic                    sat_clamp;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc_i   (acc_q),
        .opnd_i  (in_data),
        .sum_o   (sat_sum),
        .clamp_o (sat_clamp)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = sat_sum;
                    ovf_d = ovf_q | sat_clamp;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_TERMS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs decode the state register only, never the inputs.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ACCUM) || (state_q == ST_DONE);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign term_cnt  = cnt_q;

endmodule

// File: tb/tb_addsub_accum.sv
// Self-checking bench for addsub_accum: default instance (4 terms, 10 bits)
// and a narrow instance (3 terms, 6 bits) that exercises saturation.
module tb_addsub_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              start_a, in_valid_a, out_ready_a;
    logic [5:0]        in_data_a;
    logic              in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic signed [9:0] out_acc_a;
    logic [3:0]        term_cnt_a;

    logic              start_b, in_valid_b, out_ready_b;
    logic [5:0]        in_data_b;
    logic              in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic signed [5:0] out_acc_b;
    logic [3:0]        term_cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    addsub_accum u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_ready  (in_ready_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_acc   (out_acc_a),
        .out_ovf   (out_ovf_a),
        .busy      (busy_a),
        .term_cnt  (term_cnt_a)
    );

    addsub_accum #(
        .NUM_TERMS (3),
        .ACC_W     (6)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_acc   (out_acc_b),
        .out_ovf   (out_ovf_b),
        .busy      (busy_b),
        .term_cnt  (term_cnt_b)
    );

    typedef struct {
        int term;
        int exp_acc;
        int exp_cnt;
        int exp_ovf;
        int exp_valid;
    } vec_t;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: exact sum clamped to a w-bit signed range.
    function automatic int sat_ref(input int v, input int w);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic rand_run_a();
        int acc = 0;
        int ovf = 0;
        int n = 0;
        int cyc = 0;
        int t;
        int w;
        bit v;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        while (n < 4 && cyc < 100) begin
            v = ($urandom_range(0, 1) != 0);
            t = int'($urandom_range(0, 45)) - 15;
            in_valid_a = v;
            in_data_a  = t[5:0];
            if (v) begin
                if (sat_ref(acc + t, 10) != acc + t) ovf = 1;
                acc = sat_ref(acc + t, 10);
                n++;
            end
            step();
            cyc++;
        end
        in_valid_a = 1'b0;
        check("rand_a out_valid", int'(out_valid_a), 1);
        check("rand_a out_acc", int'(out_acc_a), acc);
        check("rand_a out_ovf", int'(out_ovf_a), ovf);
        check("rand_a term_cnt", int'(term_cnt_a), 4);
        w = int'($urandom_range(0, 3));
        repeat (w) step();
        check("rand_a hold acc", int'(out_acc_a), acc);
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        check("rand_a idle valid", int'(out_valid_a), 0);
    endtask

    task automatic rand_run_b();
        int acc = 0;
        int ovf = 0;
        int n = 0;
        int cyc = 0;
        int t;
        bit v;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        while (n < 3 && cyc < 100) begin
            v = ($urandom_range(0, 1) != 0);
            t = int'($urandom_range(0, 45)) - 15;
            in_valid_b = v;
            in_data_b  = t[5:0];
            if (v) begin
                if (sat_ref(acc + t, 6) != acc + t) ovf = 1;
                acc = sat_ref(acc + t, 6);
                n++;
            end
            step();
            cyc++;
        end
        in_valid_b = 1'b0;
        check("rand_b out_valid", int'(out_valid_b), 1);
        check("rand_b out_acc", int'(out_acc_b), acc);
        check("rand_b out_ovf", int'(out_ovf_b), ovf);
        check("rand_b term_cnt", int'(term_cnt_b), 3);
        out_ready_b = 1'b1;
        step();
        out_ready_b = 1'b0;
        check("rand_b idle valid", int'(out_valid_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl_a[4];
        vec_t tbl_b[3];
        int   t;
        int   xfers;
        int   cyc;
        bit   tog;

        tbl_a[0] = '{3, 3, 1, 0, 0};
        tbl_a[1] = '{5, 8, 2, 0, 0};
        tbl_a[2] = '{-2, 6, 3, 0, 0};
        tbl_a[3] = '{30, 36, 4, 0, 1};

        tbl_b[0] = '{30, 30, 1, 0, 0};
        tbl_b[1] = '{30, 31, 2, 1, 0};
        tbl_b[2] = '{-15, 16, 3, 1, 1};

        rst_n = 1'b0;
        start_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
        start_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
        step();
        step();
        check("reset in_ready", int'(in_ready_a), 0);
        check("reset out_valid", int'(out_valid_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset out_acc", int'(out_acc_a), 0);
        check("reset term_cnt", int'(term_cnt_a), 0);
        check("reset out_ovf", int'(out_ovf_a), 0);
        check("reset b busy", int'(busy_b), 0);
        rst_n = 1'b1;
        step();

        // Back-to-back terms, table driven.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        check("seq1 busy", int'(busy_a), 1);
        check("seq1 in_ready", int'(in_ready_a), 1);
        check("seq1 start acc", int'(out_acc_a), 0);
        for (int i = 0; i < 4; i++) begin
            t = tbl_a[i].term;
            in_valid_a = 1'b1;
            in_data_a  = t[5:0];
            step();
            check("seq1 acc", int'(out_acc_a), tbl_a[i].exp_acc);
            check("seq1 term_cnt", int'(term_cnt_a), tbl_a[i].exp_cnt);
            check("seq1 out_valid", int'(out_valid_a), tbl_a[i].exp_valid);
            check("seq1 in_ready", int'(in_ready_a), 1 - tbl_a[i].exp_valid);
        end
        in_valid_a = 1'b0;
        check("seq1 ovf", int'(out_ovf_a), tbl_a[3].exp_ovf);
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        check("seq1 idle valid", int'(out_valid_a), 0);
        check("seq1 idle busy", int'(busy_a), 0);
        check("seq1 idle acc held", int'(out_acc_a), 36);

        // Gapped in_valid with start held high throughout ACCUM and DONE.
        start_a = 1'b1;
        step();
        t = -15;
        in_data_a = t[5:0];
        xfers = 0;
        tog = 1'b1;
        cyc = 0;
        while (!out_valid_a && cyc < 40) begin
            in_valid_a = tog;
            if (tog && in_ready_a) xfers++;
            tog = !tog;
            step();
            cyc++;
        end
        check("seq2 reached done", int'(out_valid_a), 1);
        check("seq2 transfers", xfers, 4);
        check("seq2 acc", int'(out_acc_a), -60);
        check("seq2 term_cnt", int'(term_cnt_a), 4);
        for (int k = 0; k < 5; k++) begin
            in_valid_a = 1'b1;
            step();
            check("seq2 hold acc", int'(out_acc_a), -60);
            check("seq2 hold valid", int'(out_valid_a), 1);
            check("seq2 hold cnt", int'(term_cnt_a), 4);
        end
        start_a = 1'b0;
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;
        check("seq2 idle busy", int'(busy_a), 0);

        // Reset in the middle of a run, then a clean run.
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        in_valid_a = 1'b1;
        t = 7; in_data_a = t[5:0];
        step();
        t = 9; in_data_a = t[5:0];
        step();
        check("seq3 mid cnt", int'(term_cnt_a), 2);
        rst_n = 1'b0;
        start_a = 1'b1;
        out_ready_a = 1'b1;
        step();
        check("seq3 rst busy", int'(busy_a), 0);
        check("seq3 rst in_ready", int'(in_ready_a), 0);
        check("seq3 rst acc", int'(out_acc_a), 0);
        check("seq3 rst cnt", int'(term_cnt_a), 0);
        check("seq3 rst valid", int'(out_valid_a), 0);
        rst_n = 1'b1;
        out_ready_a = 1'b0;
        in_valid_a = 1'b0;
        step();
        start_a = 1'b0;
        check("seq3 restart busy", int'(busy_a), 1);
        for (int i = 1; i <= 4; i++) begin
            t = i;
            in_valid_a = 1'b1;
            in_data_a  = t[5:0];
            step();
        end
        in_valid_a = 1'b0;
        check("seq3 done valid", int'(out_valid_a), 1);
        check("seq3 acc", int'(out_acc_a), 10);
        check("seq3 cnt", int'(term_cnt_a), 4);
        out_ready_a = 1'b1;
        step();
        out_ready_a = 1'b0;

        // Narrow instance: saturation and sticky overflow.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t = tbl_b[i].term;
            in_valid_b = 1'b1;
            in_data_b  = t[5:0];
            step();
            check("sat acc", int'(out_acc_b), tbl_b[i].exp_acc);
            check("sat ovf", int'(out_ovf_b), tbl_b[i].exp_ovf);
            check("sat term_cnt", int'(term_cnt_b), tbl_b[i].exp_cnt);
            check("sat out_valid", int'(out_valid_b), tbl_b[i].exp_valid);
        end
        in_valid_b = 1'b0;
        out_ready_b = 1'b1;
        step();
        out_ready_b = 1'b0;
        check("sat idle busy", int'(busy_b), 0);
        check("sat idle ovf held", int'(out_ovf_b), 1);
        check("sat idle acc held", int'(out_acc_b), 16);
        start_b = 1'b1;
        out_ready_b = 1'b1;
        step();
        start_b = 1'b0;
        out_ready_b = 1'b0;
        check("restart busy", int'(busy_b), 1);
        check("restart ovf cleared", int'(out_ovf_b), 0);
        check("restart acc cleared", int'(out_acc_b), 0);

        // Randomized runs against the arithmetic reference.
        for (int r = 0; r < 20; r++) rand_run_b();
        for (int r = 0; r < 20; r++) rand_run_a();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
